// File: rtl/mem_port_arbiter.sv
// Arbitrates the single external memory bus between instruction fetch and load/store.
// One access outstanding at a time; MEM has priority, no preemption of an in-flight fetch.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  input  logic                      if_flush,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  output logic                      if_valid,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [DATA_WIDTH/8-1:0]   mem_sel,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      mem_valid,
  output logic                      bus_req,
  output logic                      bus_we,
  output logic [DATA_WIDTH/8-1:0]   bus_sel,
  output logic [ADDR_WIDTH-1:0]     bus_addr,
  output logic [DATA_WIDTH-1:0]     bus_wdata,
  input  logic [DATA_WIDTH-1:0]     bus_rdata,
  input  logic                      bus_ack,
  output logic                      stall_req_if,
  output logic                      stall_req_mem
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  state_t state;
  logic   drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      mem_rdata <= '0;
      mem_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      if_valid  <= 1'b0;
      mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Valid cycle doubles as turnaround so a just-finished request is not re-issued.
          if (!if_valid && !mem_valid) begin
            if (mem_req) begin
              bus_we    <= mem_we;
              bus_sel   <= mem_sel;
              bus_addr  <= mem_addr;
              bus_wdata <= mem_wdata;
              bus_req   <= 1'b1;
              state     <= MEM_BUSY;
            end else if (if_req) begin
              bus_we   <= 1'b0;
              bus_sel  <= '1;
              bus_addr <= if_addr;
              bus_req  <= 1'b1;
              drop     <= 1'b0;
              state    <= IF_BUSY;
            end
          end
        end
        IF_BUSY: begin
          if (if_flush) drop <= 1'b1;
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= IDLE;
            // A flush in the ack cycle itself still kills the result.
            if (!drop && !if_flush) begin
              if_rdata <= bus_rdata;
              if_valid <= 1'b1;
            end
          end
        end
        MEM_BUSY: begin
          if (bus_ack) begin
            bus_req   <= 1'b0;
            mem_rdata <= bus_rdata;
            mem_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_req_mem = mem_req & ~mem_valid;
  assign stall_req_if  = if_req & ~if_valid;

endmodule
